spi_slave: RTL

- SPI responder (slave) for the SD/SPI driver subsystem. It is the far end of the `spi` master: it is driven by the master's spi_clk, spi_cs and spi_mosi, and it returns spi_miso.
- It oversamples all SPI pins with the system clock, deserialises MOSI bytes, and serialises bytes supplied from a one-entry transmit holding register.
- Used as a bus-functional peer in master benches and as an SD-card-side emulator.

---
 rtl/spi_slave.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI responder with one-entry transmit holding register
module spi_slave #(
    parameter int         CPOL      = 1,
    parameter int         CPAH      = 1,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam logic IDLE_LVL    = (CPOL != 0);
    localparam logic SAMPLE_LEAD = (CPAH == 0);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t     state, state_nxt;
    logic       clk_s1, clk_s2, clk_prev;
    logic       cs_s1, cs_s2;
    logic       mosi_s1, mosi_s2;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_hold;
    logic       fresh;

    logic       lead_edge, trail_edge, in_frame;
    logic       sample_edge, shift_edge;
    logic       entry, exit_frame, mid_reload, reload_now;
    logic [7:0] next_byte;

    assign lead_edge   = (clk_s2 != IDLE_LVL) && (clk_prev == IDLE_LVL);
    assign trail_edge  = (clk_s2 == IDLE_LVL) && (clk_prev != IDLE_LVL);
    assign in_frame    = (state == S_ACTIVE) && !cs_s2;
    assign sample_edge = in_frame && (SAMPLE_LEAD ? lead_edge : trail_edge);
    assign shift_edge  = in_frame && (SAMPLE_LEAD ? trail_edge : lead_edge);
    assign entry       = (state == S_IDLE) && !cs_s2;
    assign exit_frame  = (state == S_ACTIVE) && cs_s2;
    // The first byte of a frame is already in tx_shift from entry; later bytes
    // are fetched at the shift edge that drives their bit 7 (byte boundary).
    assign mid_reload  = shift_edge && (bit_cnt == 3'd0) && (SAMPLE_LEAD || !fresh);
    assign reload_now  = entry || mid_reload;
    assign next_byte   = tx_full ? tx_hold : IDLE_BYTE;

    // Two-flop synchronisers for all SPI pins, plus previous-value flop for clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= IDLE_LVL;
            clk_s2   <= IDLE_LVL;
            clk_prev <= IDLE_LVL;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
        end else begin
            clk_s1   <= spi_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            cs_s1    <= spi_cs;
            cs_s2    <= cs_s1;
            mosi_s1  <= spi_mosi;
            mosi_s2  <= mosi_s1;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame follows the synchronised chip select
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!cs_s2) state_nxt = S_ACTIVE;
            S_ACTIVE: if (cs_s2)  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Busy reflects an open frame
    always_comb begin
        busy = (state == S_ACTIVE);
    end

    // Shift datapath: receive deserialiser, transmit serialiser and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_miso <= 1'b1;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            bit_cnt  <= 3'd0;
            fresh    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (exit_frame) begin
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b1;
            end else if (entry) begin
                bit_cnt <= 3'd0;
                fresh   <= 1'b1;
                if (SAMPLE_LEAD) begin
                    spi_miso <= next_byte[7];
                    tx_shift <= {next_byte[6:0], 1'b0};
                end else begin
                    tx_shift <= next_byte;
                end
            end else begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[6:0], mosi_s2};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data  <= {rx_shift[6:0], mosi_s2};
                        rx_valid <= 1'b1;
                    end
                end
                if (shift_edge) begin
                    fresh <= 1'b0;
                    if (mid_reload) begin
                        spi_miso <= next_byte[7];
                        tx_shift <= {next_byte[6:0], 1'b0};
                    end else begin
                        spi_miso <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // One-entry holding register; a load coinciding with a reload refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            tx_hold <= 8'h00;
        end else if (reload_now && tx_full) begin
            tx_full <= tx_load;
            if (tx_load) tx_hold <= tx_data;
        end else if (tx_load && !tx_full) begin
            tx_full <= 1'b1;
            tx_hold <= tx_data;
        end
    end

endmodule
